// File: rtl/cache_line_dist_pkg.sv
// Shared definitions for the cache line distribution path.
// Holds the number of beats per cache line, the distributor FSM state
// type and the master index type. Cache line select and snoop logic
// import the same package.
package cache_line_dist_pkg;

    localparam int BEATS_PER_LINE = 4;
    localparam int MASTER_IDX_W   = 4;
    localparam int BEAT_CNT_W     = $clog2(BEATS_PER_LINE);

    typedef logic [MASTER_IDX_W-1:0] master_idx_t;
    typedef logic [BEAT_CNT_W-1:0]   beat_cnt_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } line_state_e;

endpackage

// File: rtl/cache_line_dist.sv
// cache_line_dist
// Accepts one full cache line with a destination master index and
// streams it out as four beats on a data bus shared by all masters.
// Only the destination master sees a valid bit. A new line can be
// accepted in the same cycle the last beat completes, so lines stream
// back to back with no idle cycle.
//
// Ports:
//   ACLK        clock, rising edge
//   ARESETn     asynchronous active-low reset
//   line_in     full cache line (4 beats, beat 0 in the low bits)
//   dest_sel    destination master index
//   line_valid  line_in/dest_sel valid
//   line_ready  line accepted this cycle when line_valid is high
//   beat_data   current beat, shared by all masters
//   beat_valid  one-hot valid, bit = destination master
//   beat_last   current beat is the final beat of the line
//   beat_ready  per-master ready; only the destination bit is used
//   sel_err     one-cycle pulse: a line with an out-of-range index was dropped
module cache_line_dist
    import cache_line_dist_pkg::*;
#(
    parameter int DATA_SIZE   = 128,
    parameter int NUM_MASTERS = 16
) (
    input  logic                                ACLK,
    input  logic                                ARESETn,
    input  logic [DATA_SIZE*BEATS_PER_LINE-1:0] line_in,
    input  logic [MASTER_IDX_W-1:0]             dest_sel,
    input  logic                                line_valid,
    output logic                                line_ready,
    output logic [DATA_SIZE-1:0]                beat_data,
    output logic [NUM_MASTERS-1:0]              beat_valid,
    output logic                                beat_last,
    input  logic [NUM_MASTERS-1:0]              beat_ready,
    output logic                                sel_err
);

    localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(BEATS_PER_LINE - 1);

    line_state_e                         state;
    line_state_e                         next_state;
    beat_cnt_t                           beat_cnt;
    beat_cnt_t                           next_cnt;
    master_idx_t                         dest_q;
    logic [DATA_SIZE*BEATS_PER_LINE-1:0] line_q;
    logic                                sel_ok;
    logic                                line_hs;
    logic                                line_take;
    logic                                beat_hs;

    assign sel_ok   = (32'(dest_sel) < NUM_MASTERS);
    assign next_cnt = beat_cnt + beat_cnt_t'(1);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Handshake decode and next state. The beat handshake is formed by
    // masking beat_ready with the one-hot valid, so ready bits of other
    // masters never matter. line_ready opens during SEND only in the
    // cycle the last beat is taken, allowing a gapless next line.
    always_comb begin
        next_state = state;
        line_ready = 1'b0;
        beat_valid = '0;
        beat_last  = 1'b0;
        beat_hs    = 1'b0;
        line_hs    = 1'b0;
        line_take  = 1'b0;
        case (state)
            IDLE: begin
                line_ready = 1'b1;
            end
            SEND: begin
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    beat_valid[i] = (dest_q == master_idx_t'(i));
                end
                beat_last  = (beat_cnt == LAST_BEAT);
                beat_hs    = |(beat_valid & beat_ready);
                line_ready = beat_last && beat_hs;
                if (beat_last && beat_hs) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        line_hs   = line_valid && line_ready;
        line_take = line_hs && sel_ok;
        if (line_hs) begin
            next_state = sel_ok ? SEND : IDLE;
        end
    end

    // Line register and beat data. beat_data is registered rather than
    // muxed from the counter so it keeps the last beat after returning
    // to IDLE and after a dropped line.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            line_q    <= '0;
            dest_q    <= '0;
            beat_cnt  <= '0;
            beat_data <= '0;
            sel_err   <= 1'b0;
        end else begin
            sel_err <= line_hs && !sel_ok;
            if (line_take) begin
                line_q    <= line_in;
                dest_q    <= dest_sel;
                beat_cnt  <= '0;
                beat_data <= line_in[DATA_SIZE-1:0];
            end else if (beat_hs) begin
                beat_cnt <= next_cnt;
                if (!beat_last) begin
                    beat_data <= line_q[DATA_SIZE*next_cnt +: DATA_SIZE];
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_line_dist.sv
// tb_cache_line_dist
// Scoreboard bench for cache_line_dist. The stimulus side pushes the four
// expected beats of every accepted line into a queue; a monitor compares
// the DUT outputs against the head of that queue every cycle and pops it
// when the destination master is ready. A second instance with eight
// masters exercises the out-of-range destination path.
module tb_cache_line_dist;
    import cache_line_dist_pkg::*;

    localparam int DW  = 128;
    localparam int NM  = 16;
    localparam int LW  = DW * 4;
    localparam int DW2 = 8;
    localparam int NM2 = 8;

    typedef struct {
        logic [DW-1:0] data;
        int            dest;
        bit            last;
    } beat_t;

    logic            ACLK;
    logic            ARESETn;
    logic [LW-1:0]   line_in;
    logic [3:0]      dest_sel;
    logic            line_valid;
    logic            line_ready;
    logic [DW-1:0]   beat_data;
    logic [NM-1:0]   beat_valid;
    logic            beat_last;
    logic [NM-1:0]   beat_ready;
    logic            sel_err;

    logic [DW2*4-1:0] b_line_in;
    logic [3:0]       b_dest_sel;
    logic             b_line_valid;
    logic             b_line_ready;
    logic [DW2-1:0]   b_beat_data;
    logic [NM2-1:0]   b_beat_valid;
    logic             b_beat_last;
    logic [NM2-1:0]   b_beat_ready;
    logic             b_sel_err;

    beat_t         exp_q[$];
    int            checks;
    int            failures;
    int            valid_cycles;
    bit            mon_en;
    int            ready_mode;
    logic [NM-1:0] ready_fixed;

    cache_line_dist #(.DATA_SIZE(DW), .NUM_MASTERS(NM)) u_dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .line_in    (line_in),
        .dest_sel   (dest_sel),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .beat_data  (beat_data),
        .beat_valid (beat_valid),
        .beat_last  (beat_last),
        .beat_ready (beat_ready),
        .sel_err    (sel_err)
    );

    cache_line_dist #(.DATA_SIZE(DW2), .NUM_MASTERS(NM2)) u_dut8 (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .line_in    (b_line_in),
        .dest_sel   (b_dest_sel),
        .line_valid (b_line_valid),
        .line_ready (b_line_ready),
        .beat_data  (b_beat_data),
        .beat_valid (b_beat_valid),
        .beat_last  (b_beat_last),
        .beat_ready (b_beat_ready),
        .sel_err    (b_sel_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Hold line_valid until the DUT takes the line, then record its beats.
    // Called and returns at 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [LW-1:0] line, input logic [3:0] dest);
        int    waited = 0;
        bit    acc    = 1'b0;
        beat_t e;
        line_in    = line;
        dest_sel   = dest;
        line_valid = 1'b1;
        while (!acc) begin
            @(negedge ACLK);
            acc = line_ready;
            @(posedge ACLK);
            if (acc) begin
                for (int b = 0; b < 4; b++) begin
                    e.data = line[b*DW +: DW];
                    e.dest = int'(dest);
                    e.last = (b == 3);
                    exp_q.push_back(e);
                end
            end
            #1;
            if (!acc) begin
                waited++;
                if (waited > 300) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL line_accept_timeout: line not taken after %0d cycles, required accept", waited);
                    break;
                end
            end
        end
        line_valid = 1'b0;
    endtask

    task automatic drainQueue();
        int t = 0;
        while (exp_q.size() > 0 && t < 500) begin
            @(posedge ACLK);
            t++;
        end
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Ready driver, updated 2 units after each rising edge so the main
    // process can change the pattern at +1 and have it apply that cycle.
    initial begin
        forever begin
            @(posedge ACLK);
            #2;
            case (ready_mode)
                0:       beat_ready = '1;
                1:       beat_ready = NM'($urandom);
                default: beat_ready = ready_fixed;
            endcase
        end
    end

    // Monitor: every falling edge, outputs must match the head of the
    // expected queue (or be idle when it is empty).
    initial begin
        beat_t         e;
        bit            hs;
        logic [NM-1:0] ev;
        forever begin
            @(negedge ACLK);
            if (mon_en) begin
                if (|beat_valid) valid_cycles++;
                checkOutput("sel_err_main", DW'(sel_err), '0);
                if (exp_q.size() == 0) begin
                    checkOutput("idle_valid", DW'(beat_valid), '0);
                    checkOutput("idle_last", DW'(beat_last), '0);
                    checkOutput("idle_line_ready", DW'(line_ready), DW'(1));
                end else begin
                    e  = exp_q[0];
                    hs = beat_ready[e.dest];
                    ev = '0;
                    ev[e.dest] = 1'b1;
                    checkOutput("beat_valid", DW'(beat_valid), DW'(ev));
                    checkOutput("beat_data", beat_data, e.data);
                    checkOutput("beat_last", DW'(beat_last), DW'(e.last));
                    checkOutput("line_ready", DW'(line_ready), DW'(exp_q.size() == 1 && hs));
                    if (hs) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [LW-1:0] pat;
        logic [LW-1:0] rl;
        int            gap;

        checks       = 0;
        failures     = 0;
        valid_cycles = 0;
        mon_en       = 1'b0;
        ready_mode   = 2;
        ready_fixed  = '1;
        beat_ready   = '1;
        line_in      = '0;
        dest_sel     = '0;
        line_valid   = 1'b0;
        b_line_in    = '0;
        b_dest_sel   = '0;
        b_line_valid = 1'b0;
        b_beat_ready = '1;
        ARESETn      = 1'b1;
        #1 ARESETn   = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_valid", DW'(beat_valid), '0);
        checkOutput("rst_last", DW'(beat_last), '0);
        checkOutput("rst_sel_err", DW'(sel_err), '0);
        checkOutput("rst_data", beat_data, '0);
        checkOutput("rst_b_valid", DW'(b_beat_valid), '0);
        repeat (3) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        mon_en  = 1'b1;

        pat = {DW'(3), DW'(2), DW'(1), DW'(0)};

        // Destination 5, always ready: four consecutive beats.
        valid_cycles = 0;
        applyStimulus(pat, 4'd5);
        drainQueue();
        checkOutput("d5_valid_cycles", DW'(valid_cycles), DW'(4));

        // Destination 2, stall three cycles on beat 1.
        valid_cycles = 0;
        applyStimulus(pat, 4'd2);
        @(posedge ACLK);
        #1;
        ready_fixed[2] = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        ready_fixed = '1;
        drainQueue();
        checkOutput("d2_stall_valid_cycles", DW'(valid_cycles), DW'(7));

        // Back-to-back lines, destination 0 then 15.
        valid_cycles = 0;
        applyStimulus(pat, 4'd0);
        applyStimulus(~pat, 4'd15);
        drainQueue();
        checkOutput("b2b_valid_cycles", DW'(valid_cycles), DW'(8));

        // Only a non-destination master ready: no progress.
        ready_fixed = 16'h0010;
        applyStimulus(pat, 4'd3);
        repeat (5) @(posedge ACLK);
        #1;
        ready_fixed = '1;
        drainQueue();

        // Reset while beat 2 is presented.
        applyStimulus(pat, 4'd7);
        @(posedge ACLK);
        #1;
        @(posedge ACLK);
        #1;
        mon_en  = 1'b0;
        ARESETn = 1'b0;
        #1;
        checkOutput("midrst_valid", DW'(beat_valid), '0);
        checkOutput("midrst_last", DW'(beat_last), '0);
        checkOutput("midrst_data", beat_data, '0);
        checkOutput("midrst_sel_err", DW'(sel_err), '0);
        exp_q.delete();
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        checkOutput("postrst_line_ready", DW'(line_ready), DW'(1));
        checkOutput("postrst_valid", DW'(beat_valid), '0);
        @(posedge ACLK);
        #1;
        mon_en = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        applyStimulus(pat, 4'd7);
        drainQueue();

        // Randomized lines, destinations, gaps and ready.
        $display("[TB] random phase");
        ready_mode = 1;
        for (int n = 0; n < 40; n++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge ACLK);
                #1;
            end
            for (int k = 0; k < LW / 32; k++) rl[k*32 +: 32] = $urandom;
            applyStimulus(rl, 4'($urandom_range(0, 15)));
        end
        ready_mode = 0;
        drainQueue();
        mon_en = 1'b0;

        // Eight-master instance: out-of-range destination is dropped.
        $display("[TB] eight-master instance");
        b_line_in    = 32'h44332211;
        b_dest_sel   = 4'd9;
        b_line_valid = 1'b1;
        @(negedge ACLK);
        checkOutput("b_ready_before", DW'(b_line_ready), DW'(1));
        @(posedge ACLK);
        #1;
        b_line_valid = 1'b0;
        @(negedge ACLK);
        checkOutput("b_sel_err_pulse", DW'(b_sel_err), DW'(1));
        checkOutput("b_err_valid", DW'(b_beat_valid), '0);
        checkOutput("b_err_ready", DW'(b_line_ready), DW'(1));
        @(negedge ACLK);
        checkOutput("b_sel_err_clear", DW'(b_sel_err), '0);
        checkOutput("b_err_valid2", DW'(b_beat_valid), '0);
        @(posedge ACLK);
        #1;
        b_dest_sel   = 4'd3;
        b_line_valid = 1'b1;
        @(posedge ACLK);
        #1;
        b_line_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            @(negedge ACLK);
            checkOutput("b_beat_valid", DW'(b_beat_valid), DW'(8'h08));
            checkOutput("b_beat_data", DW'(b_beat_data), DW'(8'h11 * (b + 1)));
            checkOutput("b_beat_last", DW'(b_beat_last), DW'(b == 3));
        end
        @(negedge ACLK);
        checkOutput("b_done_valid", DW'(b_beat_valid), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_line_dist.md
CACHE_LINE_DIST -- requirements
Module: cache_line_dist

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 128, width in bits of one data beat (cache line = 4 beats).
REQ-002 SHALL have parameter NUM_MASTERS, default 16, number of destination master ports (1..16).
REQ-003 SHALL have ACLK  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have ARESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have line_in  input  DATA_SIZE*4  full cache line to distribute.
REQ-006 SHALL have dest_sel  input  4  destination master index.
REQ-007 SHALL have line_valid  input  1  line_in/dest_sel valid.
REQ-008 SHALL have line_ready  output  1  block accepts line this cycle.
REQ-009 SHALL have beat_data  output  DATA_SIZE  current beat, shared to all masters.
REQ-010 SHALL have beat_valid  output  NUM_MASTERS  one-hot valid, bit = destination master.
REQ-011 SHALL have beat_last  output  1  current beat is beat 3.
REQ-012 SHALL have beat_ready  input  NUM_MASTERS  per-master ready.
REQ-013 SHALL have sel_err  output  1  one-cycle pulse: line dropped, dest_sel >= NUM_MASTERS.

Function
REQ-014 SHALL implement FSM states IDLE and SEND; reset state IDLE.
REQ-015 Line handshake SHALL occur on a rising edge with line_valid=1 and line_ready=1.
REQ-016 line_ready SHALL be 1 in IDLE, and in SEND only during the cycle in which beat 3 completes its handshake; 0 otherwise.
REQ-017 On line handshake with dest_sel < NUM_MASTERS, block SHALL register line_in and dest_sel, clear beat counter to 0, and enter/stay in SEND.
REQ-018 On line handshake with dest_sel >= NUM_MASTERS, block SHALL drop the line, pulse sel_err the next cycle, and go to IDLE.
REQ-019 Beat 0 SHALL be presented the cycle after line handshake (latency 1); beat_data for beat n SHALL equal registered line bits [DATA_SIZE*(n+1)-1 : DATA_SIZE*n].
REQ-020 In SEND, beat_valid SHALL be one-hot at registered dest_sel; all other bits 0.
REQ-021 Beat handshake SHALL occur when beat_valid[d]=1 and beat_ready[d]=1; beat_ready of non-destination masters SHALL be ignored.
REQ-022 Beat counter (2 bit) SHALL increment only on beat handshake; beat_data, beat_valid, beat_last SHALL hold stable while stalled.
REQ-023 beat_last SHALL be 1 exactly when in SEND and counter = 3.
REQ-024 On beat-3 handshake: if a new valid line is accepted the same cycle, next beat 0 SHALL follow with no idle cycle; otherwise FSM SHALL return to IDLE.
REQ-025 In IDLE, beat_valid SHALL be 0, beat_last 0; beat_data don't-care but SHALL hold last value.
REQ-026 line_valid while line_ready=0 SHALL have no effect; no internal queue beyond one line register.

Reset
REQ-027 On ARESETn low, asynchronously: state IDLE, counter 0, beat_valid 0, beat_last 0, sel_err 0, line register and beat_data 0.
REQ-028 Reset mid-SEND SHALL abort the line with no further beats after ARESETn deasserts; line_ready SHALL be 1 the first cycle after deassertion.

Structure
REQ-029 Shared package SHALL hold BEATS_PER_LINE=4, the FSM state enum, and master index type (4 bit), reused by cache line select and snoop logic.
REQ-030 Implementation SHALL be a single module; no sub-module.

Verification
REQ-031 Line 0x..03_02_01_00 (beat n = n), dest 5, beat_ready[5]=1 always -> beat_valid=0x0020 for 4 consecutive cycles from cycle 1, beats 0,1,2,3, beat_last on 4th.
REQ-032 Same line, dest 2, beat_ready[2] low for 3 cycles at beat 1 -> beat 1 and outputs held stable, total 7 valid cycles, line_ready 0 throughout.
REQ-033 Back-to-back lines to dest 0 then dest 15, line_valid held -> second line accepted on first line's beat-3 handshake, 8 consecutive valid beats, valid switches 0x0001 -> 0x8000.
REQ-034 NUM_MASTERS=8, dest_sel=9 -> sel_err pulses one cycle, beat_valid stays 0, line_ready stays 1.
REQ-035 Only beat_ready[4]=1 while dest=3 -> no progress; beat 0 held until beat_ready[3] rises.
REQ-036 ARESETn low during beat 2 -> all outputs zero immediately; after release no beats, next line sent starting at beat 0.
